// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer for the Uart8 receiver: edge-detected capture into a
// show-ahead FIFO with a valid/ready read port, sticky error flags and a saturating error count.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rxByte,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic                     rdValid,
  input  logic                     rdReady,
  output logic [7:0]               rdData,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     full,
  output logic                     overflow,
  output logic                     frameErr,
  output logic [ERR_CNT_WIDTH-1:0] errCount,
  input  logic                     clearErr
);

  logic                     rx_done_q, rx_err_q;
  logic [ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]      count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     ferr_q, ferr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]               mem_q [DEPTH];

  logic                     cap_ev, err_ev, push_req, push, pop, ovf_ev;
  logic [1:0]               err_inc;
  logic [ERR_CNT_WIDTH-1:0] err_base;
  logic [ERR_CNT_WIDTH+1:0] err_sum;

  // Edge registers reset low so a done/err already high at reset release counts as an edge.
  assign cap_ev   = rxDone & ~rx_done_q;
  assign err_ev   = rxErr & ~rx_err_q;
  assign push_req = cap_ev & ~err_ev;

  assign rdValid  = (count_q != '0);
  assign full     = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign pop      = rdValid & rdReady;
  assign push     = push_req & (~full | pop);
  assign ovf_ev   = push_req & full & ~pop;

  assign rdData   = rdValid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign frameErr = ferr_q;
  assign errCount = err_cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear applies first, then this cycle's events are added on top so they are never lost.
  always_comb begin
    err_inc  = {1'b0, err_ev} + {1'b0, ovf_ev};
    err_base = clearErr ? '0 : err_cnt_q;
    err_sum  = {2'b00, err_base} + (ERR_CNT_WIDTH+2)'(err_inc);
    if (err_sum[ERR_CNT_WIDTH+1:ERR_CNT_WIDTH] != 2'b00) err_cnt_d = '1;
    else                                                 err_cnt_d = err_sum[ERR_CNT_WIDTH-1:0];
    ovf_d  = (ovf_q  & ~clearErr) | ovf_ev;
    ferr_d = (ferr_q & ~clearErr) | err_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rx_done_q <= rxDone;
      rx_err_q  <= rxErr;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rxByte;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int EW    = 8;
  localparam int EMAX  = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rxByte;
  logic          rxDone, rxErr, rdReady, clearErr;
  logic          rdValid, full, overflow, frameErr;
  logic [7:0]    rdData;
  logic [AW:0]   count;
  logic [EW-1:0] errCount;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .rxByte(rxByte), .rxDone(rxDone), .rxErr(rxErr),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .count(count), .full(full),
    .overflow(overflow), .frameErr(frameErr), .errCount(errCount), .clearErr(clearErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned mq[$];
  bit m_ovf, m_ferr, m_pd, m_pe;
  int m_ecnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_ferr = 0; m_ecnt = 0; m_pd = 0; m_pe = 0;
  endtask

  task automatic check_all();
    chk("count",    32'(count),    32'(mq.size()));
    chk("rdValid",  32'(rdValid),  32'(mq.size() != 0));
    chk("rdData",   32'(rdData),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frameErr", 32'(frameErr), 32'(m_ferr));
    chk("errCount", 32'(errCount), 32'(m_ecnt));
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cyc(input bit d, input bit e, input logic [7:0] b, input bit r, input bit c);
    bit cap, ev, pp, ov;
    int sz;
    rxDone = d; rxErr = e; rxByte = b; rdReady = r; clearErr = c;
    cap = d && !m_pd;
    ev  = e && !m_pe;
    sz  = mq.size();
    pp  = (sz != 0) && r;
    ov  = 0;
    if (pp) void'(mq.pop_front());
    if (cap && !ev) begin
      if (sz < DEPTH || pp) mq.push_back(b);
      else ov = 1;
    end
    if (c) begin m_ovf = 0; m_ferr = 0; m_ecnt = 0; end
    if (ov) m_ovf = 1;
    if (ev) m_ferr = 1;
    m_ecnt = m_ecnt + int'(ov) + int'(ev);
    if (m_ecnt > EMAX) m_ecnt = EMAX;
    m_pd = d; m_pe = e;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] b);
    cyc(1, 0, b, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    reset = 1'b1; rxByte = '0; rxDone = 0; rxErr = 0; rdReady = 0; clearErr = 0;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_rdData", 32'(rdData), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();

    // single byte
    cyc(1, 0, 8'h6A, 0, 0);
    chk("single_valid", 32'(rdValid), 1);
    chk("single_data",  32'(rdData),  32'h6A);
    chk("single_count", 32'(count),   1);
    cyc(0, 0, 8'h00, 1, 0);
    chk("single_pop_valid", 32'(rdValid), 0);
    chk("single_pop_count", 32'(count),   0);

    // held done
    repeat (5) cyc(1, 0, 8'h56, 0, 0);
    chk("held_count", 32'(count), 1);
    cyc(0, 0, 8'h00, 1, 0);

    // fill and overflow
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", 32'(full), 1);
    cyc(1, 0, 8'hFF, 0, 0);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_ecnt",  32'(errCount), 1);
    chk("ovf_count", 32'(count),    16);
    cyc(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rdData), 32'(i));
      cyc(0, 0, 8'h00, 1, 0);
    end
    cyc(0, 0, 8'h00, 0, 1);
    chk("clear_ovf", 32'(overflow), 0);

    // wrap-around
    for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + i));
    repeat (10) cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) push_byte(8'(8'h40 + i));
    chk("wrap_count", 32'(count), 12);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h80 + i));
    chk("wrap_full", 32'(full), 1);
    cyc(1, 0, 8'hC3, 1, 0);
    chk("fullpp_count", 32'(count),    16);
    chk("fullpp_ovf",   32'(overflow), 0);
    cyc(0, 0, 8'h00, 0, 0);
    repeat (16) cyc(0, 0, 8'h00, 1, 0);

    // frame error
    push_byte(8'h11);
    cyc(1, 1, 8'h55, 0, 0);
    chk("ferr_flag",  32'(frameErr), 1);
    chk("ferr_ecnt",  32'(errCount), 1);
    chk("ferr_count", 32'(count),    1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ferr_clr_flag", 32'(frameErr), 0);
    chk("ferr_clr_ecnt", 32'(errCount), 0);
    chk("ferr_clr_data", 32'(rdData),   32'h11);
    cyc(0, 0, 8'h00, 1, 0);

    // saturation, then async reset mid-drain
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
    end
    chk("sat_ecnt", 32'(errCount), 32'hFF);
    for (int i = 0; i < 7; i++) push_byte(8'(8'hA0 + i));
    repeat (2) cyc(0, 0, 8'h00, 1, 0);
    chk("pre_rst_count", 32'(count), 5);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(rdValid),  0);
    chk("arst_count", 32'(count),    0);
    chk("arst_ecnt",  32'(errCount), 0);
    model_reset();
    rxDone = 1; rxByte = 8'hA5; rdReady = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(1, 0, 8'hA5, 0, 0);
    chk("done_at_release", 32'(count), 1);
    cyc(0, 0, 8'h00, 1, 0);

    // randomized traffic with alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      bit d, e, r, c;
      d = ($urandom_range(0, 99) < 45);
      e = ($urandom_range(0, 99) < 4);
      r = ((i / 250) % 2 == 1) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 99) < 2);
      cyc(d, e, 8'($urandom), r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
